// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - FSM state encodings (also exported on the debug state port)
//   - opcode constants for the decoded instruction classes
//   - alu_op, alu_src_b and pc_src mux encodings
//   - op_defined(): true for every opcode the controller can sequence
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_FUNCT = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_ADD   = 2'b11;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic op_defined(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: op_defined = 1'b1;
         default:                                              op_defined = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_mc_wait_timer.sv
// ---------------------------------------------------------------------------
// mips_mc_wait_timer
// Counts consecutive memory-wait cycles (mem_ready low while the FSM is in a
// memory-access state) and flags a timeout once WAIT_MAX such cycles have
// already elapsed and memory is still not ready. WAIT_MAX = 0 disables it.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_waiting       FSM is in FETCH or MEM
//   i_mem_ready     memory completes this cycle
//   i_state_chg     FSM changes state at the next edge; clears the count
//   o_timeout       combinational timeout / mem_err pulse
// ---------------------------------------------------------------------------
module mips_mc_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_waiting,
   input  logic i_mem_ready,
   input  logic i_state_chg,
   output logic o_timeout
);

   // Keep at least one counter bit so WAIT_MAX = 0 still elaborates.
   localparam int              CNT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_stall;

   assign w_stall = i_waiting && !i_mem_ready;

   // Saturate rather than wrap, which only matters with the timeout disabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_state_chg) begin
         r_cnt <= '0;
      end else if (w_stall && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // mem_ready high in the same cycle wins because w_stall is then low.
   assign o_timeout = (WAIT_MAX != 0) && w_stall && (r_cnt == CNT_MAX);

endmodule

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
// Multi-cycle MIPS control FSM: IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB.
// Decodes R-type, j, beq, bne, addi, lw and sw; waits on a memory-ready
// handshake in FETCH and MEM with a WAIT_MAX timeout (mem_err, back to IDLE).
// Optional feature macro: MIPS_CTRL_ILLEGAL_TRAP_EN
//   defined   - undefined opcode enters TRAP (left only by reset), illegal set
//   undefined - undefined opcode acts as a NOP, illegal tied low
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_run                   leave IDLE (sampled only in IDLE)
//   i_opcode                IR opcode field, sampled in DECODE
//   i_mem_ready             memory access completes this cycle
//   o_pc_write .. o_pc_src  datapath controls
//   o_state                 current state (debug)
//   o_instr_done            pulse on the last cycle of an instruction
//   o_mem_err               pulse on a memory-wait timeout
//   o_illegal               sticky undefined-opcode flag
// ---------------------------------------------------------------------------
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int WAIT_MAX = 15
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_run,
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic                i_mem_ready,
   output logic                o_pc_write,
   output logic                o_ir_write,
   output logic                o_i_or_d,
   output logic                o_reg_dst,
   output logic                o_memto_reg,
   output logic                o_alu_src_a,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic                o_reg_write,
   output logic                o_branch,
   output logic                o_branch_ne,
   output logic [1:0]          o_alu_op,
   output logic [1:0]          o_alu_src_b,
   output logic [1:0]          o_pc_src,
   output logic [2:0]          o_state,
   output logic                o_instr_done,
   output logic                o_mem_err,
   output logic                o_illegal
);

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_op_q;
   logic       w_op_ok;
   logic       w_timeout;

   // Any set bit above the 6-bit opcode field makes the opcode undefined.
   assign w_op_ok = ((i_opcode >> 6) == '0) && op_defined(i_opcode[5:0]);

   mips_mc_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_waiting   ((r_state == ST_FETCH) || (r_state == ST_MEM)),
      .i_mem_ready (i_mem_ready),
      .i_state_chg (w_next != r_state),
      .o_timeout   (w_timeout)
   );

   assign o_mem_err = w_timeout;
   assign o_state   = r_state;

   // State register and opcode latch
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_op_q  <= OP_RTYPE;
      end else begin
         r_state <= w_next;
         if (r_state == ST_DECODE) begin
            r_op_q <= i_opcode[5:0];
         end
      end
   end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic r_illegal;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_illegal <= 1'b0;
      end else if ((r_state == ST_DECODE) && !w_op_ok) begin
         r_illegal <= 1'b1;
      end
   end

   assign o_illegal = r_illegal;
`else
   assign o_illegal = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_run) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (i_mem_ready)    w_next = ST_DECODE;
            else if (w_timeout) w_next = ST_IDLE;
         end
         ST_DECODE: begin
            if (w_op_ok) begin
               w_next = ST_EXEC;
            end else begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               w_next = ST_TRAP;
`else
               w_next = ST_FETCH;
`endif
            end
         end
         ST_EXEC: begin
            case (r_op_q)
               OP_RTYPE, OP_ADDI: w_next = ST_WB;
               OP_LW, OP_SW:      w_next = ST_MEM;
               default:           w_next = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (i_mem_ready)    w_next = (r_op_q == OP_LW) ? ST_WB : ST_FETCH;
            else if (w_timeout) w_next = ST_IDLE;
         end
         ST_WB:   w_next = ST_FETCH;
         ST_TRAP: w_next = ST_TRAP;
         default: w_next = ST_IDLE;
      endcase
   end

   // Output decode; IDLE and TRAP keep every control at its default 0.
   always_comb begin
      o_pc_write   = 1'b0;
      o_ir_write   = 1'b0;
      o_i_or_d     = 1'b0;
      o_reg_dst    = 1'b0;
      o_memto_reg  = 1'b0;
      o_alu_src_a  = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_reg_write  = 1'b0;
      o_branch     = 1'b0;
      o_branch_ne  = 1'b0;
      o_alu_op     = ALU_FUNCT;
      o_alu_src_b  = SRCB_REG;
      o_pc_src     = PCSRC_ALU;
      o_instr_done = 1'b0;
      case (r_state)
         ST_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = SRCB_FOUR;
            o_alu_op    = ALU_ADD;
            // IR load and PC+4 commit only when the fetch actually returns.
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
         end
         ST_DECODE: begin
            // Speculative branch target: PC + (imm << 2).
            o_alu_src_b = SRCB_IMM_SL2;
            o_alu_op    = ALU_ADD;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            // Undefined opcodes trap; the instruction never completes.
`else
            o_instr_done = !w_op_ok;
`endif
         end
         ST_EXEC: begin
            case (r_op_q)
               OP_RTYPE: begin
                  o_alu_src_a = 1'b1;
                  o_alu_src_b = SRCB_REG;
                  o_alu_op    = ALU_FUNCT;
               end
               OP_LW, OP_SW, OP_ADDI: begin
                  o_alu_src_a = 1'b1;
                  o_alu_src_b = SRCB_IMM;
                  o_alu_op    = ALU_ADD;
               end
               OP_BEQ, OP_BNE: begin
                  o_alu_src_a  = 1'b1;
                  o_alu_src_b  = SRCB_REG;
                  o_alu_op     = ALU_SUB;
                  o_pc_src     = PCSRC_ALUOUT;
                  o_branch     = (r_op_q == OP_BEQ);
                  o_branch_ne  = (r_op_q == OP_BNE);
                  o_instr_done = 1'b1;
               end
               OP_J: begin
                  o_pc_write   = 1'b1;
                  o_pc_src     = PCSRC_JUMP;
                  o_instr_done = 1'b1;
               end
               default: begin
               end
            endcase
         end
         ST_MEM: begin
            o_i_or_d     = 1'b1;
            o_mem_read   = (r_op_q == OP_LW);
            o_mem_write  = (r_op_q == OP_SW);
            o_instr_done = (r_op_q == OP_SW) && i_mem_ready;
         end
         ST_WB: begin
            o_reg_dst    = (r_op_q == OP_RTYPE);
            o_memto_reg  = (r_op_q == OP_LW);
            o_reg_write  = 1'b1;
            o_instr_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Directed bench for mips_mc_ctrl (WAIT_MAX = 3). Inputs change on the
// falling edge; outputs are sampled 1 time unit later. The control bus is
// compared as one packed vector against hand-built constants:
//   {pc_write, ir_write, i_or_d, reg_dst, memto_reg, alu_src_a, mem_read,
//    mem_write, reg_write, branch, branch_ne, alu_op[1:0], alu_src_b[1:0],
//    pc_src[1:0], instr_done}
// Works with or without MIPS_CTRL_ILLEGAL_TRAP_EN defined.
// ---------------------------------------------------------------------------
module tb_mips_mc_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                          S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP = 3'd6;

   localparam logic [17:0] C_ZERO  = 18'b00000000000_00_00_00_0;
   localparam logic [17:0] C_F     = 18'b11000010000_11_01_00_0;
   localparam logic [17:0] C_FW    = 18'b00000010000_11_01_00_0;
   localparam logic [17:0] C_D     = 18'b00000000000_11_11_00_0;
   localparam logic [17:0] C_DNOP  = 18'b00000000000_11_11_00_1;
   localparam logic [17:0] C_ER    = 18'b00000100000_00_00_00_0;
   localparam logic [17:0] C_EI    = 18'b00000100000_11_10_00_0;
   localparam logic [17:0] C_EBEQ  = 18'b00000100010_01_00_01_1;
   localparam logic [17:0] C_EBNE  = 18'b00000100001_01_00_01_1;
   localparam logic [17:0] C_EJ    = 18'b10000000000_00_00_10_1;
   localparam logic [17:0] C_MLW   = 18'b00100010000_00_00_00_0;
   localparam logic [17:0] C_MSWW  = 18'b00100001000_00_00_00_0;
   localparam logic [17:0] C_MSW   = 18'b00100001000_00_00_00_1;
   localparam logic [17:0] C_WBR   = 18'b00010000100_00_00_00_1;
   localparam logic [17:0] C_WBI   = 18'b00000000100_00_00_00_1;
   localparam logic [17:0] C_WBL   = 18'b00001000100_00_00_00_1;

   logic       clk = 1'b0;
   logic       rst_n, run, mem_ready;
   logic [5:0] opcode;
   logic       pc_write, ir_write, i_or_d, reg_dst, memto_reg, alu_src_a;
   logic       mem_read, mem_write, reg_write, branch, branch_ne;
   logic [1:0] alu_op, alu_src_b, pc_src;
   logic [2:0] state;
   logic       instr_done, mem_err, illegal;
   logic [17:0] ctl;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mips_mc_ctrl #(.OPCODE_W(6), .WAIT_MAX(3)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_run        (run),
      .i_opcode     (opcode),
      .i_mem_ready  (mem_ready),
      .o_pc_write   (pc_write),
      .o_ir_write   (ir_write),
      .o_i_or_d     (i_or_d),
      .o_reg_dst    (reg_dst),
      .o_memto_reg  (memto_reg),
      .o_alu_src_a  (alu_src_a),
      .o_mem_read   (mem_read),
      .o_mem_write  (mem_write),
      .o_reg_write  (reg_write),
      .o_branch     (branch),
      .o_branch_ne  (branch_ne),
      .o_alu_op     (alu_op),
      .o_alu_src_b  (alu_src_b),
      .o_pc_src     (pc_src),
      .o_state      (state),
      .o_instr_done (instr_done),
      .o_mem_err    (mem_err),
      .o_illegal    (illegal)
   );

   assign ctl = {pc_write, ir_write, i_or_d, reg_dst, memto_reg, alu_src_a, mem_read,
                 mem_write, reg_write, branch, branch_ne, alu_op, alu_src_b, pc_src, instr_done};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Check one cycle (state, control bus, mem_err, illegal), then advance.
   task automatic step(input string tag, input logic [2:0] st, input logic [17:0] c,
                       input logic err);
      #1;
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".ctl"}, 32'(ctl), 32'(c));
      chk({tag, ".err"}, 32'(mem_err), 32'(err));
      chk({tag, ".ill"}, 32'(illegal), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; run = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
      #1;
      chk("rst.state", 32'(state), 32'(S_IDLE));
      chk("rst.ctl", 32'(ctl), 32'(C_ZERO));
      chk("rst.err", 32'(mem_err), 32'd0);
      chk("rst.ill", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("idle_norun", S_IDLE, C_ZERO, 1'b0);
      run = 1'b1;
      step("idle_run", S_IDLE, C_ZERO, 1'b0);
      run = 1'b0;   // instruction stream continues without run

      // R-type: 4 cycles, instr_done on the 4th
      step("r.f", S_FETCH, C_F, 1'b0);
      step("r.d", S_DEC, C_D, 1'b0);
      step("r.e", S_EXEC, C_ER, 1'b0);
      step("r.wb", S_WB, C_WBR, 1'b0);

      // lw with two mem-wait cycles: 7 cycles
      opcode = 6'b100011;
      step("lw.f", S_FETCH, C_F, 1'b0);
      step("lw.d", S_DEC, C_D, 1'b0);
      step("lw.e", S_EXEC, C_EI, 1'b0);
      mem_ready = 1'b0;
      step("lw.m0", S_MEM, C_MLW, 1'b0);
      step("lw.m1", S_MEM, C_MLW, 1'b0);
      mem_ready = 1'b1;
      step("lw.m2", S_MEM, C_MLW, 1'b0);
      step("lw.wb", S_WB, C_WBL, 1'b0);

      // beq then bne: 3 cycles each
      opcode = 6'b000100;
      step("beq.f", S_FETCH, C_F, 1'b0);
      step("beq.d", S_DEC, C_D, 1'b0);
      step("beq.e", S_EXEC, C_EBEQ, 1'b0);
      opcode = 6'b000101;
      step("bne.f", S_FETCH, C_F, 1'b0);
      step("bne.d", S_DEC, C_D, 1'b0);
      step("bne.e", S_EXEC, C_EBNE, 1'b0);

      // j: 3 cycles
      opcode = 6'b000010;
      step("j.f", S_FETCH, C_F, 1'b0);
      step("j.d", S_DEC, C_D, 1'b0);
      step("j.e", S_EXEC, C_EJ, 1'b0);

      // addi: 4 cycles, rt destination
      opcode = 6'b001000;
      step("addi.f", S_FETCH, C_F, 1'b0);
      step("addi.d", S_DEC, C_D, 1'b0);
      step("addi.e", S_EXEC, C_EI, 1'b0);
      step("addi.wb", S_WB, C_WBI, 1'b0);

      // sw: 4 cycles, done in MEM
      opcode = 6'b101011;
      step("sw.f", S_FETCH, C_F, 1'b0);
      step("sw.d", S_DEC, C_D, 1'b0);
      step("sw.e", S_EXEC, C_EI, 1'b0);
      step("sw.m", S_MEM, C_MSW, 1'b0);

      // Fetch timeout with WAIT_MAX=3: mem_err on the 4th wait cycle
      mem_ready = 1'b0;
      step("to.w1", S_FETCH, C_FW, 1'b0);
      step("to.w2", S_FETCH, C_FW, 1'b0);
      step("to.w3", S_FETCH, C_FW, 1'b0);
      step("to.w4", S_FETCH, C_FW, 1'b1);
      mem_ready = 1'b1;
      step("to.idle", S_IDLE, C_ZERO, 1'b0);
      run = 1'b1;
      step("to.rerun", S_IDLE, C_ZERO, 1'b0);
      run = 1'b0;

      // Async reset while sw is waiting in MEM
      opcode = 6'b101011;
      step("swr.f", S_FETCH, C_F, 1'b0);
      step("swr.d", S_DEC, C_D, 1'b0);
      step("swr.e", S_EXEC, C_EI, 1'b0);
      mem_ready = 1'b0;
      #1;
      chk("swr.m.state", 32'(state), 32'(S_MEM));
      chk("swr.m.ctl", 32'(ctl), 32'(C_MSWW));
      #2;
      rst_n = 1'b0;
      #1;
      chk("swr.rst.state", 32'(state), 32'(S_IDLE));
      chk("swr.rst.mw", 32'(mem_write), 32'd0);
      chk("swr.rst.ctl", 32'(ctl), 32'(C_ZERO));
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1; run = 1'b1;
      step("ill.idle", S_IDLE, C_ZERO, 1'b0);

      // Undefined opcode 111111
      opcode = 6'b111111;
      step("ill.f", S_FETCH, C_F, 1'b0);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      step("ill.d", S_DEC, C_D, 1'b0);
      #1;
      chk("trap.state", 32'(state), 32'(S_TRAP));
      chk("trap.ill", 32'(illegal), 32'd1);
      chk("trap.ctl", 32'(ctl), 32'(C_ZERO));
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      #1;
      chk("trap.hold.state", 32'(state), 32'(S_TRAP));
      chk("trap.hold.ill", 32'(illegal), 32'd1);
`else
      step("ill.d", S_DEC, C_DNOP, 1'b0);
      opcode = 6'b000000;
      step("ill.nop.f", S_FETCH, C_F, 1'b0);
      step("ill.nop.d", S_DEC, C_D, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
